// File: rtl/pmci_csr_arb_if.sv
// Bus bundle for the PMCI CSR arbiter: two requester ports in packed form,
// the shared target CSR port and the stray-response status flag.
interface pmci_csr_arb_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) ();
    // Requester side
    logic [1:0]                  req_valid;
    logic [1:0]                  req_write;
    logic [2*ADDR_WIDTH-1:0]     req_addr;
    logic [2*DATA_WIDTH-1:0]     req_wdata;
    logic [2*DATA_WIDTH/8-1:0]   req_wstrb;
    logic [1:0]                  req_ready;
    logic [1:0]                  rsp_valid;
    logic [DATA_WIDTH-1:0]       rsp_rdata;
    logic                        rsp_err;

    // Target side
    logic                        tgt_valid;
    logic                        tgt_write;
    logic [ADDR_WIDTH-1:0]       tgt_addr;
    logic [DATA_WIDTH-1:0]       tgt_wdata;
    logic [DATA_WIDTH/8-1:0]     tgt_wstrb;
    logic                        tgt_ready;
    logic                        tgt_rsp_valid;
    logic [DATA_WIDTH-1:0]       tgt_rdata;

    // Status
    logic                        stray_rsp;

    // Arbiter view
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output tgt_valid, tgt_write, tgt_addr, tgt_wdata, tgt_wstrb,
        input  tgt_ready, tgt_rsp_valid, tgt_rdata,
        output stray_rsp
    );

    // Environment view: requesters plus the CSR target
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  tgt_valid, tgt_write, tgt_addr, tgt_wdata, tgt_wstrb,
        output tgt_ready, tgt_rsp_valid, tgt_rdata,
        input  stray_rsp
    );
endinterface

// File: rtl/pmci_csr_arb.sv
// PMCI CSR arbiter: round-robin between two requesters onto a single
// SPI-bridge CSR port, one transaction in flight, with a timeout that forces
// an all-ones error completion when the target stalls.
module pmci_csr_arb #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 1024
) (
    input  logic          clk,
    input  logic          rst,
    pmci_csr_arb_if.slave bus
);
    localparam int          STRB_WIDTH = DATA_WIDTH / 8;
    // Last timer value allowed before the transaction is forced to complete.
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                  state_r, state_nx_s;
    logic [15:0]             timer_r, timer_nx_s, timer_inc_s;
    logic                    timeout_s;
    logic                    grant_s;
    logic                    g_r, g_nx_s;
    logic                    last_g_r, last_g_nx_s;

    logic                    sel_write_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;
    logic [STRB_WIDTH-1:0]   sel_wstrb_s;

    logic [1:0]              req_ready_r, req_ready_nx_s;
    logic [1:0]              rsp_valid_r, rsp_valid_nx_s;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r, rsp_rdata_nx_s;
    logic                    rsp_err_r, rsp_err_nx_s;
    logic                    tgt_valid_r, tgt_valid_nx_s;
    logic                    tgt_write_r, tgt_write_nx_s;
    logic [ADDR_WIDTH-1:0]   tgt_addr_r, tgt_addr_nx_s;
    logic [DATA_WIDTH-1:0]   tgt_wdata_r, tgt_wdata_nx_s;
    logic [STRB_WIDTH-1:0]   tgt_wstrb_r, tgt_wstrb_nx_s;
    logic                    stray_r, stray_nx_s;

    // Round-robin pick: on a tie the requester that did not go last wins.
    always_comb begin
        if (bus.req_valid == 2'b11) begin
            grant_s = ~last_g_r;
        end else if (bus.req_valid[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Select the command fields of the requester being granted.
    always_comb begin
        if (grant_s) begin
            sel_write_s = bus.req_write[1];
            sel_addr_s  = bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
            sel_wdata_s = bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
            sel_wstrb_s = bus.req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH];
        end else begin
            sel_write_s = bus.req_write[0];
            sel_addr_s  = bus.req_addr[ADDR_WIDTH-1:0];
            sel_wdata_s = bus.req_wdata[DATA_WIDTH-1:0];
            sel_wstrb_s = bus.req_wstrb[STRB_WIDTH-1:0];
        end
    end

    // Saturating timer increment and timeout detect.
    always_comb begin
        if (timer_r == 16'hFFFF) begin
            timer_inc_s = timer_r;
        end else begin
            timer_inc_s = timer_r + 16'd1;
        end
        timeout_s = (timer_r >= TMO_LAST);
    end

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_nx_s     = state_r;
        timer_nx_s     = timer_r;
        g_nx_s         = g_r;
        last_g_nx_s    = last_g_r;
        req_ready_nx_s = 2'b00;
        rsp_valid_nx_s = 2'b00;
        rsp_rdata_nx_s = rsp_rdata_r;
        rsp_err_nx_s   = rsp_err_r;
        tgt_valid_nx_s = tgt_valid_r;
        tgt_write_nx_s = tgt_write_r;
        tgt_addr_nx_s  = tgt_addr_r;
        tgt_wdata_nx_s = tgt_wdata_r;
        tgt_wstrb_nx_s = tgt_wstrb_r;
        // A target completion anywhere but WAIT is unexpected and sticky.
        stray_nx_s     = stray_r | (bus.tgt_rsp_valid & (state_r != ST_WAIT));

        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid != 2'b00) begin
                    g_nx_s                  = grant_s;
                    req_ready_nx_s[grant_s] = 1'b1;
                    tgt_valid_nx_s          = 1'b1;
                    tgt_write_nx_s          = sel_write_s;
                    tgt_addr_nx_s           = sel_addr_s;
                    tgt_wdata_nx_s          = sel_wdata_s;
                    tgt_wstrb_nx_s          = sel_wstrb_s;
                    timer_nx_s              = 16'd0;
                    state_nx_s              = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                timer_nx_s = timer_inc_s;
                if (bus.tgt_ready) begin
                    // Handshake completes the command phase even on the last
                    // timer cycle; the response phase is then bounded by WAIT.
                    tgt_valid_nx_s = 1'b0;
                    state_nx_s     = ST_WAIT;
                end else if (timeout_s) begin
                    tgt_valid_nx_s = 1'b0;
                    rsp_rdata_nx_s = '1;
                    rsp_err_nx_s   = 1'b1;
                    state_nx_s     = ST_RESP;
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                timer_nx_s = timer_inc_s;
                if (bus.tgt_rsp_valid) begin
                    // Real completion beats a simultaneous timeout.
                    rsp_rdata_nx_s = bus.tgt_rdata;
                    rsp_err_nx_s   = 1'b0;
                    state_nx_s     = ST_RESP;
                end else if (timeout_s) begin
                    rsp_rdata_nx_s = '1;
                    rsp_err_nx_s   = 1'b1;
                    state_nx_s     = ST_RESP;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                rsp_valid_nx_s[g_r] = 1'b1;
                last_g_nx_s         = g_r;
                state_nx_s          = ST_IDLE;
            end
            default: begin
                tgt_valid_nx_s = 1'b0;
                state_nx_s     = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Registered datapath, arbitration history and all module outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r     <= 16'd0;
            g_r         <= 1'b0;
            last_g_r    <= 1'b1;
            req_ready_r <= 2'b00;
            rsp_valid_r <= 2'b00;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
            tgt_valid_r <= 1'b0;
            tgt_write_r <= 1'b0;
            tgt_addr_r  <= '0;
            tgt_wdata_r <= '0;
            tgt_wstrb_r <= '0;
            stray_r     <= 1'b0;
        end else begin
            timer_r     <= timer_nx_s;
            g_r         <= g_nx_s;
            last_g_r    <= last_g_nx_s;
            req_ready_r <= req_ready_nx_s;
            rsp_valid_r <= rsp_valid_nx_s;
            rsp_rdata_r <= rsp_rdata_nx_s;
            rsp_err_r   <= rsp_err_nx_s;
            tgt_valid_r <= tgt_valid_nx_s;
            tgt_write_r <= tgt_write_nx_s;
            tgt_addr_r  <= tgt_addr_nx_s;
            tgt_wdata_r <= tgt_wdata_nx_s;
            tgt_wstrb_r <= tgt_wstrb_nx_s;
            stray_r     <= stray_nx_s;
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.tgt_valid = tgt_valid_r;
    assign bus.tgt_write = tgt_write_r;
    assign bus.tgt_addr  = tgt_addr_r;
    assign bus.tgt_wdata = tgt_wdata_r;
    assign bus.tgt_wstrb = tgt_wstrb_r;
    assign bus.stray_rsp = stray_r;

endmodule

// File: tb/tb_pmci_csr_arb.sv
// Directed self-checking bench for pmci_csr_arb (TIMEOUT=8).
module tb_pmci_csr_arb;
    localparam int AW  = 10;
    localparam int DW  = 64;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   n;
    logic [1:0]  exp_g;
    logic [63:0] rd;

    pmci_csr_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    pmci_csr_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.req_valid     = 2'b00;
        bus.req_write     = 2'b00;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.req_wstrb     = '0;
        bus.tgt_ready     = 1'b0;
        bus.tgt_rsp_valid = 1'b0;
        bus.tgt_rdata     = '0;
        #2;
        chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 64'h0);
        chk("rst_rsp_err",   64'(bus.rsp_err), 64'h0);
        chk("rst_tgt_valid", 64'(bus.tgt_valid), 64'h0);
        chk("rst_tgt_addr",  64'(bus.tgt_addr), 64'h0);
        chk("rst_stray",     64'(bus.stray_rsp), 64'h0);
        tick;
        tick;
        rst = 1'b0;

        // Read from requester 0, minimum latency.
        bus.req_valid = 2'b01;
        bus.req_write = 2'b00;
        bus.req_addr  = {10'h000, 10'h040};
        tick;
        chk("rd_req_ready", 64'(bus.req_ready), 64'h1);
        chk("rd_tgt_valid", 64'(bus.tgt_valid), 64'h1);
        chk("rd_tgt_write", 64'(bus.tgt_write), 64'h0);
        chk("rd_tgt_addr",  64'(bus.tgt_addr), 64'h040);
        bus.req_valid = 2'b00;
        bus.tgt_ready = 1'b1;
        tick;
        bus.tgt_ready = 1'b0;
        chk("rd_tgt_drop",  64'(bus.tgt_valid), 64'h0);
        chk("rd_ready_lo",  64'(bus.req_ready), 64'h0);
        bus.tgt_rsp_valid = 1'b1;
        bus.tgt_rdata     = 64'h1122_3344_5566_7788;
        tick;
        bus.tgt_rsp_valid = 1'b0;
        chk("rd_rsp_early", 64'(bus.rsp_valid), 64'h0);
        tick;
        chk("rd_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("rd_rsp_rdata", bus.rsp_rdata, 64'h1122_3344_5566_7788);
        chk("rd_rsp_err",   64'(bus.rsp_err), 64'h0);
        chk("rd_stray",     64'(bus.stray_rsp), 64'h0);
        tick;
        chk("rd_rsp_pulse", 64'(bus.rsp_valid), 64'h0);
        chk("rd_rdata_hold", bus.rsp_rdata, 64'h1122_3344_5566_7788);

        // Write from requester 1, target never ready: timeout.
        bus.req_valid = 2'b10;
        bus.req_write = 2'b10;
        bus.req_addr  = {10'h3F8, 10'h000};
        bus.req_wdata = {64'hDEAD_BEEF_CAFE_F00D, 64'h0};
        bus.req_wstrb = {8'h0F, 8'h00};
        tick;
        chk("tmo_req_ready", 64'(bus.req_ready), 64'h2);
        chk("tmo_tgt_write", 64'(bus.tgt_write), 64'h1);
        chk("tmo_tgt_addr",  64'(bus.tgt_addr), 64'h3F8);
        chk("tmo_tgt_wdata", bus.tgt_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        chk("tmo_tgt_wstrb", 64'(bus.tgt_wstrb), 64'h0F);
        chk("tmo_tgt_valid0", 64'(bus.tgt_valid), 64'h1);
        bus.req_valid = 2'b00;
        for (int i = 1; i < 8; i++) begin
            tick;
            chk("tmo_tgt_valid", 64'(bus.tgt_valid), 64'h1);
        end
        tick;
        chk("tmo_tgt_drop", 64'(bus.tgt_valid), 64'h0);
        chk("tmo_rsp_early", 64'(bus.rsp_valid), 64'h0);
        tick;
        chk("tmo_rsp_valid", 64'(bus.rsp_valid), 64'h2);
        chk("tmo_rsp_rdata", bus.rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("tmo_rsp_err",   64'(bus.rsp_err), 64'h1);

        // Late completion arriving in IDLE.
        bus.tgt_rsp_valid = 1'b1;
        bus.tgt_rdata     = 64'h5555_AAAA_5555_AAAA;
        tick;
        bus.tgt_rsp_valid = 1'b0;
        chk("late_stray",     64'(bus.stray_rsp), 64'h1);
        chk("late_no_rsp",    64'(bus.rsp_valid), 64'h0);
        tick;
        chk("late_stray_hold", 64'(bus.stray_rsp), 64'h1);
        chk("late_no_rsp2",   64'(bus.rsp_valid), 64'h0);

        // Completion on the same cycle the timer reaches TIMEOUT-1.
        bus.req_valid = 2'b01;
        bus.req_write = 2'b00;
        bus.req_addr  = {10'h000, 10'h080};
        tick;
        chk("race_req_ready", 64'(bus.req_ready), 64'h1);
        bus.req_valid = 2'b00;
        bus.tgt_ready = 1'b1;
        tick;
        bus.tgt_ready = 1'b0;
        chk("race_tgt_drop", 64'(bus.tgt_valid), 64'h0);
        for (int i = 2; i < 8; i++) begin
            tick;
            chk("race_no_rsp", 64'(bus.rsp_valid), 64'h0);
        end
        bus.tgt_rsp_valid = 1'b1;
        bus.tgt_rdata     = 64'h0BAD_F00D_1234_5678;
        tick;
        bus.tgt_rsp_valid = 1'b0;
        chk("race_rsp_early", 64'(bus.rsp_valid), 64'h0);
        tick;
        chk("race_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("race_rsp_rdata", bus.rsp_rdata, 64'h0BAD_F00D_1234_5678);
        chk("race_rsp_err",   64'(bus.rsp_err), 64'h0);
        chk("race_stray",     64'(bus.stray_rsp), 64'h1);

        // Reset while in WAIT.
        bus.req_valid = 2'b10;
        bus.req_write = 2'b00;
        bus.req_addr  = {10'h2C0, 10'h000};
        tick;
        chk("wrst_req_ready", 64'(bus.req_ready), 64'h2);
        bus.req_valid = 2'b00;
        bus.tgt_ready = 1'b1;
        tick;
        bus.tgt_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("wrst_req_ready0", 64'(bus.req_ready), 64'h0);
        chk("wrst_rsp_valid",  64'(bus.rsp_valid), 64'h0);
        chk("wrst_rsp_rdata",  bus.rsp_rdata, 64'h0);
        chk("wrst_rsp_err",    64'(bus.rsp_err), 64'h0);
        chk("wrst_tgt_valid",  64'(bus.tgt_valid), 64'h0);
        chk("wrst_tgt_addr",   64'(bus.tgt_addr), 64'h0);
        chk("wrst_stray",      64'(bus.stray_rsp), 64'h0);

        // Both requesters valid continuously from reset release.
        bus.req_valid = 2'b11;
        bus.req_write = 2'b00;
        bus.req_addr  = {10'h208, 10'h100};
        tick;
        tick;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_g = ((k % 2) == 0) ? 2'b01 : 2'b10;
            rd    = 64'hA5A5_0000_0000_0000 | 64'(k);
            n = 0;
            do begin
                tick;
                n++;
            end while (bus.req_ready == 2'b00 && n < 8);
            chk("rr_grant", 64'(bus.req_ready), 64'(exp_g));
            chk("rr_addr",  64'(bus.tgt_addr), ((k % 2) == 0) ? 64'h100 : 64'h208);
            bus.tgt_ready = 1'b1;
            tick;
            bus.tgt_ready = 1'b0;
            chk("rr_ready_wait", 64'(bus.req_ready), 64'h0);
            bus.tgt_rsp_valid = 1'b1;
            bus.tgt_rdata     = rd;
            tick;
            bus.tgt_rsp_valid = 1'b0;
            chk("rr_ready_resp", 64'(bus.req_ready), 64'h0);
            tick;
            chk("rr_rsp_valid", 64'(bus.rsp_valid), 64'(exp_g));
            chk("rr_rsp_rdata", bus.rsp_rdata, rd);
            chk("rr_ready_done", 64'(bus.req_ready), 64'h0);
        end
        bus.req_valid = 2'b00;
        tick;
        chk("post_rr_stray", 64'(bus.stray_rsp), 64'h0);

        // First post-reset completion outside WAIT.
        bus.tgt_rsp_valid = 1'b1;
        tick;
        bus.tgt_rsp_valid = 1'b0;
        chk("prst_stray",  64'(bus.stray_rsp), 64'h1);
        chk("prst_no_rsp", 64'(bus.rsp_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pmci_csr_arb.md
PMCI_CSR_ARB -- requirements
Module: pmci_csr_arb

Interface
- REQ-001: Parameter ADDR_WIDTH, default 10, CSR byte-address width.
- REQ-002: Parameter DATA_WIDTH, default 64, CSR data width.
- REQ-003: Parameter TIMEOUT, default 1024, max cycles spent in ISSUE+WAIT before forced completion; legal range 2..65535.
- REQ-004: clk  input  1  sole clock; one clock domain, all logic on rising edge.
- REQ-005: rst  input  1  asynchronous, active-high reset.
- REQ-006: req_valid  input  2  per-requester command valid; bit i belongs to requester i.
- REQ-007: req_write  input  2  per-requester: 1 = write, 0 = read.
- REQ-008: req_addr  input  2*ADDR_WIDTH  packed addresses; slice i belongs to requester i.
- REQ-009: req_wdata  input  2*DATA_WIDTH  packed write data.
- REQ-010: req_wstrb  input  2*DATA_WIDTH/8  packed byte strobes.
- REQ-011: req_ready  output  2  one-cycle accept pulse to the granted requester.
- REQ-012: rsp_valid  output  2  one-cycle completion pulse to the granted requester.
- REQ-013: rsp_rdata  output  DATA_WIDTH  completion data, shared by both requesters, qualified by rsp_valid.
- REQ-014: rsp_err  output  1  timeout flag, qualified by rsp_valid.
- REQ-015: tgt_valid, tgt_write  output  1 each  command to the shared SPI-bridge CSR port.
- REQ-016: tgt_addr / tgt_wdata / tgt_wstrb  output  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  latched command fields.
- REQ-017: tgt_ready  input  1  target accepts command.
- REQ-018: tgt_rsp_valid, tgt_rdata  input  1 / DATA_WIDTH  target completion; write completions carry don't-care data.
- REQ-019: stray_rsp  output  1  sticky flag: tgt_rsp_valid seen outside WAIT.

Function
- REQ-020: FSM states: IDLE, ISSUE, WAIT, RESP. Only one transaction is outstanding at any time.
- REQ-021: IDLE, any req_valid:
  - grant requester g by round-robin; the requester other than last_g wins a tie;
  - pulse req_ready[g]; latch write/addr/wdata/wstrb; clear timer; go to ISSUE.
- REQ-022: IDLE, single requester valid: grant it regardless of last_g.
- REQ-023: ISSUE: drive tgt_valid=1 with the latched fields, held stable until tgt_ready; on tgt_ready go to WAIT.
- REQ-024: Timer increments every cycle in ISSUE and WAIT.
- REQ-025: WAIT, tgt_rsp_valid: capture tgt_rdata, set err=0, go to RESP.
- REQ-026: ISSUE or WAIT, timer==TIMEOUT-1 with no completion that cycle:
  - set rdata to all-ones and err=1, go to RESP;
  - drop tgt_valid if still in ISSUE.
- REQ-027: Completion and timeout in the same cycle: the completion wins (err=0, real data).
- REQ-028: RESP: pulse rsp_valid[g] for one cycle with rsp_rdata/rsp_err; set last_g=g; return to IDLE.
- REQ-029: Accept-to-rsp_valid latency = 3 + (ISSUE wait cycles) + (WAIT cycles); minimum 3 cycles when tgt_ready and tgt_rsp_valid each arrive on their first eligible cycle.
- REQ-030: tgt_rsp_valid in IDLE, ISSUE or RESP is ignored for data and sets stray_rsp; stray_rsp stays set until reset.
- REQ-031: A requester dropping req_valid after req_ready has no effect on the in-flight transaction.
- REQ-032: rsp_rdata holds its last value between completions.
- REQ-033: All outputs are registered.

Reset
- REQ-034: On rst assertion, immediately and regardless of clk:
  - state=IDLE, last_g=1 (requester 0 wins the first tie), timer=0;
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0;
  - tgt_valid=0, tgt_write=0, tgt_addr=0, tgt_wdata=0, tgt_wstrb=0, stray_rsp=0.
- REQ-035: Reset mid-transaction abandons it with no rsp_valid. The first post-reset tgt_rsp_valid, if outside WAIT, sets stray_rsp.

Verification
- REQ-036: Read, requester 0:
  - addr 0x040, target ready on first ISSUE cycle, rsp next cycle with 0x1122334455667788;
  - expect rsp_valid[0] 3 cycles after req_ready[0], rdata matches, err=0.
- REQ-037: Both requesters assert req_valid continuously from reset:
  - grants alternate 0,1,0,1 over 4 transactions;
  - req_ready never asserted while a transaction is in flight.
- REQ-038: TIMEOUT=8, target never asserts tgt_ready:
  - tgt_valid high for 8 cycles, then drops;
  - rsp_valid with rdata=all-ones, err=1.
- REQ-039: TIMEOUT=8, tgt_rsp_valid on the same cycle the timer hits 7:
  - expect err=0 and the real data.
- REQ-040: Timed-out transaction followed by a late tgt_rsp_valid while in IDLE:
  - stray_rsp=1 and no rsp_valid pulse;
  - stray_rsp returns to 0 only on rst.
- REQ-041: rst asserted while in WAIT:
  - all outputs zero immediately;
  - the next request is granted to requester 0.
